mem_stage_reg: RTL and testbench
================================

// Module: mem_stage_reg
// PURPOSE
//  Memory pipeline stage: consumer end of the EXE->MEM valid/allowin handshake.
//  Latches EXE results, performs one data-memory access per load/store over a req/addr_ok/data_ok bus,
//  and hands the completed instruction to WB through the MEM->WB valid/allowin handshake.
//  Non-memory instructions pass through in one cycle; memory instructions stall in MEM until data_ok.
// PARAMETERS
//  DATA_W   32  datapath / bus data width
//  RFZIP_W  6   width of {rf_we, rf_waddr[4:0]}
// PORTS
//  clk               in   1       clock; all state changes on posedge
//  reset             in   1       asynchronous, active-high reset
//  mem_allowin       out  1       MEM can accept an instruction from EXE this cycle
//  exe_to_mem_valid  in   1       EXE presents a valid instruction
//  exe_pc            in   32      instruction PC
//  exe_alu_result    in   32      ALU result; doubles as data address
//  exe_res_from_mem  in   1       load: writeback value comes from memory
//  exe_mem_we        in   1       store
//  exe_rkd_value     in   32      store data
//  exe_rf_zip        in   6       {rf_we, rf_waddr}
//  data_req          out  1       bus request
//  data_wr           out  1       1 = write, 0 = read
//  data_addr         out  32      byte address (word access only)
//  data_wdata        out  32      write data
//  data_addr_ok      in   1       request accepted (handshake with data_req)
//  data_data_ok      in   1       read data valid / write acknowledged
//  data_rdata        in   32      read data
//  wb_allowin        in   1       WB can accept
//  mem_to_wb_valid   out  1       MEM presents a completed instruction
//  mem_pc            out  32      PC to WB
//  mem_rf_zip        out  6       {rf_we, rf_waddr}; rf_we forced 0 when stage invalid (hazard use)
//  mem_rf_wdata      out  32      load data or ALU result
// BEHAVIOUR
//  - Reset (async): mem_valid=0, FSM=IDLE, data_req=0, mem_to_wb_valid=0, all payload regs 0.
//  - Accept: on posedge with exe_to_mem_valid & mem_allowin, latch payload, mem_valid<=1;
//    else if mem_to_wb_valid & wb_allowin, mem_valid<=0.
//  - mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin); mem_to_wb_valid = mem_valid & mem_ready_go.
//  - is_mem = res_from_mem | mem_we. Non-mem: mem_ready_go=1 (1-cycle latency), FSM stays IDLE.
//  - FSM (mem instructions): IDLE -> REQ on accept of an is_mem instruction.
//    REQ: data_req=1, wr/addr/wdata stable; addr_ok -> WAIT. data_req held until addr_ok.
//    WAIT: data_ok -> if wb_allowin: IDLE (or REQ if a new is_mem instr accepted same edge) else DONE.
//    DONE: rdata held in resp buffer; wb_allowin -> IDLE/REQ as above.
//  - data_ok arrives no earlier than the cycle after addr_ok; one outstanding request max.
//  - mem_ready_go = (WAIT & data_ok) | DONE for is_mem; response captured into buffer on data_ok.
//  - mem_rf_wdata = res_from_mem ? (DONE ? buffered rdata : data_rdata) : alu_result.
//  - Stores: same FSM, write completes on data_ok; rf_we expected 0.
//  - Back-to-back: completing instr and next EXE instr may swap on the same edge; no bubble for ALU ops.
//  - data_ok while IDLE/REQ is ignored (protocol violation; assertion in bench).
//  - Reset mid-access: FSM to IDLE, request dropped; memory side is reset in the same cycle.
//  - data_addr[1:0] forwarded unchanged; alignment checks are not this block's job.
// STRUCTURE
//  - mycpu_pkg: RFZIP_W, mem FSM state enum {IDLE,REQ,WAIT,DONE}, EXE->MEM payload bus width.
//  - Single module; FSM and 32-bit response buffer inline. No sub-module.
// TESTING
//  - ALU op: exe_alu_result=0x1234, rf_zip=6'h25, wb_allowin=1 -> next cycle mem_to_wb_valid=1,
//    mem_rf_wdata=0x1234, no data_req.
//  - Load addr 0x100, addr_ok after 2 cycles, data_ok 1 cycle later with 0xDEADBEEF -> data_req 3 cycles,
//    mem_to_wb_valid only in data_ok cycle, mem_rf_wdata=0xDEADBEEF.
//  - Load with wb_allowin=0 at data_ok -> DONE, rdata 0xCAFEF00D held, emitted when wb_allowin rises;
//    mem_allowin=0 throughout.
//  - Store addr 0x200 data 0x55AA55AA followed by ALU op -> data_wr=1, ALU op accepted on data_ok edge,
//    leaves 1 cycle later.
//  - Assert reset during WAIT -> data_req, mem_valid, mem_to_wb_valid 0 immediately; later data_ok ignored.
//  - Random wb_allowin and bus delays, 1000 instrs -> WB PC order equals EXE order, none lost/duplicated.

Source files
------------

// File: rtl/mem_stage_reg_pkg.sv
// Shared types and widths for the MEM pipeline stage.
package mem_stage_reg_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_RFZIP_W = 6;
  // pc, alu_result, rkd_value, res_from_mem, mem_we, rf_zip
  localparam int EXE_MEM_BUS_W = 3 * DEF_DATA_W + 2 + DEF_RFZIP_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } mem_state_e;

  function automatic logic is_mem_op(input logic res_from_mem, input logic mem_we);
    return res_from_mem | mem_we;
  endfunction

endpackage

// File: rtl/mem_stage_reg_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
interface mem_stage_reg_if
  import mem_stage_reg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              data_req;
  logic              data_wr;
  logic [DATA_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface

// File: rtl/mem_stage_reg.sv
// MEM pipeline stage: latches EXE results, performs one data-memory access per
// load/store over the req/addr_ok/data_ok bus and hands results to WB.
module mem_stage_reg
  import mem_stage_reg_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RFZIP_W = DEF_RFZIP_W
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_allowin,
  input  logic               exe_to_mem_valid,
  input  logic [DATA_W-1:0]  exe_pc,
  input  logic [DATA_W-1:0]  exe_alu_result,
  input  logic               exe_res_from_mem,
  input  logic               exe_mem_we,
  input  logic [DATA_W-1:0]  exe_rkd_value,
  input  logic [RFZIP_W-1:0] exe_rf_zip,
  mem_stage_reg_if.master    data_bus,
  input  logic               wb_allowin,
  output logic               mem_to_wb_valid,
  output logic [DATA_W-1:0]  mem_pc,
  output logic [RFZIP_W-1:0] mem_rf_zip,
  output logic [DATA_W-1:0]  mem_rf_wdata
);

  logic               r_mem_valid;
  logic [DATA_W-1:0]  r_pc;
  logic [DATA_W-1:0]  r_alu_result;
  logic [DATA_W-1:0]  r_rkd_value;
  logic               r_res_from_mem;
  logic               r_mem_we;
  logic [RFZIP_W-1:0] r_rf_zip;
  logic [DATA_W-1:0]  r_resp_buf;

  mem_state_e r_state;
  mem_state_e w_next_state;
  mem_state_e w_after_wb;

  logic w_is_mem;
  logic w_exe_is_mem;
  logic w_rsp_fire;
  logic w_ready_go;
  logic w_accept;
  logic w_wb_fire;

  assign w_is_mem        = is_mem_op(r_res_from_mem, r_mem_we);
  assign w_exe_is_mem    = is_mem_op(exe_res_from_mem, exe_mem_we);
  assign mem_allowin     = !r_mem_valid || (w_ready_go && wb_allowin);
  assign mem_to_wb_valid = r_mem_valid && w_ready_go;
  assign w_accept        = exe_to_mem_valid && mem_allowin;
  assign w_wb_fire       = mem_to_wb_valid && wb_allowin;
  // A swap on the handoff edge restarts the FSM for the incoming instruction.
  assign w_after_wb      = (w_accept && w_exe_is_mem) ? S_REQ : S_IDLE;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default assignment first keeps this combinational block latch-free.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_exe_is_mem) w_next_state = S_REQ;
      S_REQ:   if (data_bus.data_addr_ok) w_next_state = S_WAIT;
      S_WAIT:  if (data_bus.data_data_ok) w_next_state = wb_allowin ? w_after_wb : S_DONE;
      S_DONE:  if (wb_allowin) w_next_state = w_after_wb;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    data_bus.data_req = (r_state == S_REQ);
    w_rsp_fire        = (r_state == S_WAIT) && data_bus.data_data_ok;
    w_ready_go        = w_is_mem ? (w_rsp_fire || (r_state == S_DONE)) : 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_mem_valid <= 1'b0;
    else if (w_accept)  r_mem_valid <= 1'b1;
    else if (w_wb_fire) r_mem_valid <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc           <= '0;
      r_alu_result   <= '0;
      r_rkd_value    <= '0;
      r_res_from_mem <= 1'b0;
      r_mem_we       <= 1'b0;
      r_rf_zip       <= '0;
    end else if (w_accept) begin
      r_pc           <= exe_pc;
      r_alu_result   <= exe_alu_result;
      r_rkd_value    <= exe_rkd_value;
      r_res_from_mem <= exe_res_from_mem;
      r_mem_we       <= exe_mem_we;
      r_rf_zip       <= exe_rf_zip;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_resp_buf <= '0;
    else if (w_rsp_fire) r_resp_buf <= data_bus.data_rdata;
  end

  assign data_bus.data_wr    = r_mem_we;
  assign data_bus.data_addr  = r_alu_result;
  assign data_bus.data_wdata = r_rkd_value;

  assign mem_pc       = r_pc;
  assign mem_rf_zip   = {r_rf_zip[RFZIP_W-1] & r_mem_valid, r_rf_zip[RFZIP_W-2:0]};
  assign mem_rf_wdata = r_res_from_mem ? ((r_state == S_DONE) ? r_resp_buf : data_bus.data_rdata)
                                       : r_alu_result;

endmodule

// File: tb/tb_mem_stage_reg.sv
// Self-checking bench for mem_stage_reg: directed scenarios plus a randomized
// stream checked against a transaction-level model of the stage.
module tb_mem_stage_reg;

  localparam int N_RANDOM     = 1000;
  localparam int CYCLE_BUDGET = 40000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rkd;
    logic        res_from_mem;
    logic        mem_we;
    logic [5:0]  rf_zip;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_allowin;
  logic        exe_to_mem_valid;
  logic [31:0] exe_pc;
  logic [31:0] exe_alu_result;
  logic        exe_res_from_mem;
  logic        exe_mem_we;
  logic [31:0] exe_rkd_value;
  logic [5:0]  exe_rf_zip;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [31:0] mem_pc;
  logic [5:0]  mem_rf_zip;
  logic [31:0] mem_rf_wdata;

  // Bus inputs: directed values from the main sequence, random ones from the responder.
  logic        auto_mem = 1'b0;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] d_rdata;
  logic        r_addr_ok, r_data_ok;
  logic [31:0] r_rdata;

  mem_stage_reg_if #(.DATA_W(32)) bus ();

  assign bus.data_addr_ok = auto_mem ? r_addr_ok : d_addr_ok;
  assign bus.data_data_ok = auto_mem ? r_data_ok : d_data_ok;
  assign bus.data_rdata   = auto_mem ? r_rdata   : d_rdata;

  mem_stage_reg #(.DATA_W(32), .RFZIP_W(6)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_allowin      (mem_allowin),
    .exe_to_mem_valid (exe_to_mem_valid),
    .exe_pc           (exe_pc),
    .exe_alu_result   (exe_alu_result),
    .exe_res_from_mem (exe_res_from_mem),
    .exe_mem_we       (exe_mem_we),
    .exe_rkd_value    (exe_rkd_value),
    .exe_rf_zip       (exe_rf_zip),
    .data_bus         (bus),
    .wb_allowin       (wb_allowin),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .mem_pc           (mem_pc),
    .mem_rf_zip       (mem_rf_zip),
    .mem_rf_wdata     (mem_rf_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input instr_t ins);
    exe_to_mem_valid = 1'b1;
    exe_pc           = ins.pc;
    exe_alu_result   = ins.alu;
    exe_rkd_value    = ins.rkd;
    exe_res_from_mem = ins.res_from_mem;
    exe_mem_we       = ins.mem_we;
    exe_rf_zip       = ins.rf_zip;
  endtask

  function automatic instr_t mk(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rkd,
                                input logic ld, input logic st, input logic [5:0] zip);
    instr_t t;
    t.pc = pc; t.alu = alu; t.rkd = rkd; t.res_from_mem = ld; t.mem_we = st; t.rf_zip = zip;
    return t;
  endfunction

  function automatic instr_t rand_instr(input logic [31:0] pc);
    int   kind;
    logic we;
    kind = $urandom_range(0, 2);
    we   = (kind == 1) ? 1'b1 : (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    return mk(pc, $urandom, $urandom, kind == 1, kind == 2, {we, 5'($urandom_range(0, 31))});
  endfunction

  // Transaction-level model: at most one instruction lives in MEM; a memory op
  // owes one address handshake then one response before it may leave.
  instr_t      stage_q[$];
  bit          req_done, resp_got;
  logic [31:0] resp_data;
  bit          mon_on = 1'b0;
  int          retired = 0;

  task automatic monitor_cycle();
    instr_t cur;
    bit     legal, ready, mem_op;
    if (bus.data_data_ok) begin
      legal = stage_q.size() == 1 && (stage_q[0].res_from_mem || stage_q[0].mem_we) && req_done && !resp_got;
      check("data_ok_legal", 32'(legal), 32'd1);
      if (legal) begin
        resp_got  = 1'b1;
        resp_data = bus.data_rdata;
      end
    end
    if (stage_q.size() == 0) begin
      check("idle_wb_valid", 32'(mem_to_wb_valid), 32'd0);
      check("idle_allowin", 32'(mem_allowin), 32'd1);
      check("idle_req", 32'(bus.data_req), 32'd0);
      check("idle_rf_we", 32'(mem_rf_zip[5]), 32'd0);
    end else begin
      cur    = stage_q[0];
      mem_op = cur.res_from_mem || cur.mem_we;
      ready  = mem_op ? resp_got : 1'b1;
      check("mon_req", 32'(bus.data_req), 32'(mem_op && !req_done));
      check("mon_wb_valid", 32'(mem_to_wb_valid), 32'(ready));
      check("mon_allowin", 32'(mem_allowin), 32'(ready && wb_allowin));
      check("mon_pc", mem_pc, cur.pc);
      check("mon_rf_zip", 32'(mem_rf_zip), 32'(cur.rf_zip));
      if (ready) check("mon_rf_wdata", mem_rf_wdata, cur.res_from_mem ? resp_data : cur.alu);
      if (bus.data_req) begin
        check("mon_addr", bus.data_addr, cur.alu);
        check("mon_wr", 32'(bus.data_wr), 32'(cur.mem_we));
        if (cur.mem_we) check("mon_wdata", bus.data_wdata, cur.rkd);
        if (bus.data_addr_ok) req_done = 1'b1;
      end
      if (ready && wb_allowin) begin
        void'(stage_q.pop_front());
        retired++;
      end
    end
    if (exe_to_mem_valid && mem_allowin) begin
      stage_q.push_back(mk(exe_pc, exe_alu_result, exe_rkd_value, exe_res_from_mem, exe_mem_we, exe_rf_zip));
      req_done = 1'b0;
      resp_got = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      stage_q.delete();
      req_done = 1'b0;
      resp_got = 1'b0;
    end else if (mon_on) begin
      monitor_cycle();
    end
  end

  // Random memory: addr_ok at random while idle, data_ok 1..4 cycles after the address handshake.
  initial begin : mem_responder
    bit pending;
    int dly;
    bit hs_addr, hs_data;
    pending = 1'b0; dly = 0;
    r_addr_ok = 1'b0; r_data_ok = 1'b0; r_rdata = '0;
    forever begin
      @(negedge clk);
      hs_addr = bus.data_req && bus.data_addr_ok;
      hs_data = bus.data_data_ok;
      @(posedge clk);
      #1;
      if (auto_mem) begin
        if (hs_data) pending = 1'b0;
        if (hs_addr) begin
          pending = 1'b1;
          dly     = $urandom_range(0, 3);
        end
        r_addr_ok = !pending && ($urandom_range(0, 2) == 0);
        r_data_ok = pending && (dly == 0);
        if (pending && dly > 0) dly--;
        r_rdata = $urandom;
      end else begin
        pending = 1'b0;
        r_addr_ok = 1'b0;
        r_data_ok = 1'b0;
      end
    end
  end

  initial begin : main
    int          req_cycles, wbv_cycles, base_retired, presented;
    bit          acc;
    logic [31:0] pc;

    reset = 1'b1;
    exe_to_mem_valid = 1'b0; exe_pc = '0; exe_alu_result = '0; exe_rkd_value = '0;
    exe_res_from_mem = 1'b0; exe_mem_we = 1'b0; exe_rf_zip = '0; wb_allowin = 1'b1;
    d_addr_ok = 1'b0; d_data_ok = 1'b0; d_rdata = '0;

    #12;
    check("rst_wb_valid", 32'(mem_to_wb_valid), 32'd0);
    check("rst_req", 32'(bus.data_req), 32'd0);
    check("rst_allowin", 32'(mem_allowin), 32'd1);
    check("rst_pc", mem_pc, 32'd0);
    check("rst_rf_zip", 32'(mem_rf_zip), 32'd0);
    check("rst_rf_wdata", mem_rf_wdata, 32'd0);
    reset  = 1'b0;
    mon_on = 1'b1;
    tick();

    // ALU op: one-cycle pass-through, no bus request.
    drive_instr(mk(32'h1000, 32'h1234, 32'h0, 1'b0, 1'b0, 6'h25));
    tick();
    exe_to_mem_valid = 1'b0;
    #1;
    check("alu_wb_valid", 32'(mem_to_wb_valid), 32'd1);
    check("alu_rf_wdata", mem_rf_wdata, 32'h1234);
    check("alu_rf_zip", 32'(mem_rf_zip), 32'h25);
    check("alu_no_req", 32'(bus.data_req), 32'd0);
    tick();
    check("alu_gone", 32'(mem_to_wb_valid), 32'd0);

    // Load: addr_ok on the third request cycle, data_ok the cycle after.
    drive_instr(mk(32'h1004, 32'h100, 32'h0, 1'b1, 1'b0, 6'h23));
    tick();
    exe_to_mem_valid = 1'b0;
    req_cycles = 0; wbv_cycles = 0;
    for (int c = 0; c < 4; c++) begin
      d_addr_ok = (c == 2);
      d_data_ok = (c == 3);
      d_rdata   = (c == 3) ? 32'hDEADBEEF : $urandom;
      #1;
      if (bus.data_req) begin
        req_cycles++;
        check("ld_addr", bus.data_addr, 32'h100);
      end
      if (mem_to_wb_valid) begin
        wbv_cycles++;
        check("ld_wb_cycle", 32'(c), 32'd3);
        check("ld_rf_wdata", mem_rf_wdata, 32'hDEADBEEF);
      end
      tick();
    end
    d_addr_ok = 1'b0; d_data_ok = 1'b0;
    #1;
    check("ld_req_cycles", 32'(req_cycles), 32'd3);
    check("ld_wbv_cycles", 32'(wbv_cycles), 32'd1);
    check("ld_gone", 32'(mem_to_wb_valid), 32'd0);

    // Load stalled by WB: response held, next ALU op waits until WB accepts.
    wb_allowin = 1'b0;
    drive_instr(mk(32'h1008, 32'h104, 32'h0, 1'b1, 1'b0, 6'h27));
    tick();
    drive_instr(mk(32'h100C, 32'h77, 32'h0, 1'b0, 1'b0, 6'h31));
    d_addr_ok = 1'b1;
    #1;
    check("stall_allowin_req", 32'(mem_allowin), 32'd0);
    tick();
    d_addr_ok = 1'b0; d_data_ok = 1'b1; d_rdata = 32'hCAFEF00D;
    #1;
    check("stall_wb_valid", 32'(mem_to_wb_valid), 32'd1);
    check("stall_allowin_ok", 32'(mem_allowin), 32'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      d_data_ok = 1'b0; d_rdata = $urandom;
      #1;
      check("done_rf_wdata", mem_rf_wdata, 32'hCAFEF00D);
      check("done_allowin", 32'(mem_allowin), 32'd0);
      check("done_wb_valid", 32'(mem_to_wb_valid), 32'd1);
      tick();
    end
    wb_allowin = 1'b1;
    #1;
    check("done_release", 32'(mem_allowin), 32'd1);
    tick();
    exe_to_mem_valid = 1'b0;
    #1;
    check("after_done_pc", mem_pc, 32'h100C);
    check("after_done_wdata", mem_rf_wdata, 32'h77);
    tick();

    // Store followed by ALU op: ALU enters on the data_ok edge.
    drive_instr(mk(32'h1010, 32'h200, 32'h55AA55AA, 1'b0, 1'b1, 6'h00));
    tick();
    drive_instr(mk(32'h1014, 32'hABC, 32'h0, 1'b0, 1'b0, 6'h2A));
    d_addr_ok = 1'b1;
    #1;
    check("st_wr", 32'(bus.data_wr), 32'd1);
    check("st_wdata", bus.data_wdata, 32'h55AA55AA);
    check("st_addr", bus.data_addr, 32'h200);
    tick();
    d_addr_ok = 1'b0; d_data_ok = 1'b1;
    #1;
    check("st_wb_valid", 32'(mem_to_wb_valid), 32'd1);
    check("st_allowin", 32'(mem_allowin), 32'd1);
    tick();
    exe_to_mem_valid = 1'b0; d_data_ok = 1'b0;
    #1;
    check("st_next_pc", mem_pc, 32'h1014);
    check("st_next_valid", 32'(mem_to_wb_valid), 32'd1);
    tick();
    check("st_next_gone", 32'(mem_to_wb_valid), 32'd0);

    // Reset while requesting, then while waiting for data.
    mon_on = 1'b0;
    drive_instr(mk(32'h1018, 32'h300, 32'h0, 1'b1, 1'b0, 6'h21));
    tick();
    exe_to_mem_valid = 1'b0;
    #1;
    check("rreq_pre", 32'(bus.data_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rreq_req", 32'(bus.data_req), 32'd0);
    check("rreq_allowin", 32'(mem_allowin), 32'd1);
    #2 reset = 1'b0;
    tick();
    wb_allowin = 1'b0;
    drive_instr(mk(32'h101C, 32'h304, 32'h0, 1'b1, 1'b0, 6'h22));
    tick();
    exe_to_mem_valid = 1'b0;
    d_addr_ok = 1'b1;
    tick();
    d_addr_ok = 1'b0; d_data_ok = 1'b1; d_rdata = 32'h12345678;
    #1;
    check("rwait_pre", 32'(mem_to_wb_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rwait_wb_valid", 32'(mem_to_wb_valid), 32'd0);
    check("rwait_req", 32'(bus.data_req), 32'd0);
    check("rwait_allowin", 32'(mem_allowin), 32'd1);
    check("rwait_rf_we", 32'(mem_rf_zip[5]), 32'd0);
    #2 reset = 1'b0;
    tick();
    #1;
    check("late_ok_wb_valid", 32'(mem_to_wb_valid), 32'd0);
    check("late_ok_req", 32'(bus.data_req), 32'd0);
    tick();
    d_data_ok = 1'b0;
    wb_allowin = 1'b1;
    mon_on = 1'b1;
    tick();

    // Random stream against the model.
    auto_mem     = 1'b1;
    base_retired = retired;
    presented    = 0;
    pc           = 32'h4000;
    for (int cyc = 0; cyc < CYCLE_BUDGET && (retired - base_retired) < N_RANDOM; cyc++) begin
      @(negedge clk);
      acc = exe_to_mem_valid && mem_allowin;
      tick();
      if (acc || !exe_to_mem_valid) begin
        if (presented < N_RANDOM && $urandom_range(0, 3) != 0) begin
          drive_instr(rand_instr(pc));
          pc += 4;
          presented++;
        end else begin
          exe_to_mem_valid = 1'b0;
        end
      end
      wb_allowin = ($urandom_range(0, 9) < 7);
    end
    check("random_retired", 32'(retired - base_retired), 32'(N_RANDOM));
    exe_to_mem_valid = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
